// File: rtl/paint_pkg.sv
// paint_pkg: shared types and constants for the paint framebuffer.
//   rgb_t            24-bit RGB color (R in [23:16], G in [15:8], B in [7:0])
//   ERASE..PURPLE    named color codes stored in the pixel RAM
//   DEFAULT_PALETTE  power-up colors for codes 0..7
//   default_color()  default color for any code; codes >= 8 are black
//   clr_state_t      clear-engine states
package paint_pkg;

  typedef logic [23:0] rgb_t;

  localparam int ERASE  = 0;
  localparam int WHITE  = 1;
  localparam int BLACK  = 2;
  localparam int RED    = 3;
  localparam int BLUE   = 4;
  localparam int YELLOW = 5;
  localparam int GREEN  = 6;
  localparam int PURPLE = 7;

  // BLACK is deliberately 000001 so a drawn black pixel differs from an
  // erased (000000) one.
  localparam rgb_t DEFAULT_PALETTE [8] = '{
    24'h000000, 24'hFFFFFF, 24'h000001, 24'hFF0000,
    24'h0000FF, 24'hFFFF00, 24'h00FF00, 24'hFF00FF
  };

  function automatic rgb_t default_color(input int idx);
    rgb_t c;
    c = '0;
    if (idx >= 0 && idx < 8) c = DEFAULT_PALETTE[idx[2:0]];
    return c;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/paint_palette.sv
// paint_palette: 2**CW x 24-bit color lookup table, second read-pipeline stage.
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   we, idx,     palette write port: entry idx takes color at the clock edge
//   color
//   code         color code from the first read stage
//   rd_data      registered palette[code]; reads the pre-write entry when a
//                write to the same index happens in the same cycle
module paint_palette
  import paint_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [CW-1:0] idx,
  input  rgb_t          color,
  input  logic [CW-1:0] code,
  output rgb_t          rd_data
);

  localparam int ENTRIES = 2 ** CW;

  rgb_t pal [ENTRIES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) pal[i] <= default_color(i);
      rd_data <= '0;
    end else begin
      if (we) pal[idx] <= color;
      rd_data <= pal[code];
    end
  end

endmodule

// File: rtl/paint_framebuffer.sv
// paint_framebuffer: WIDTH x HEIGHT color-code pixel RAM with palette lookup,
// hardware clear engine and dropped-write reporting.
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   wren, wr_addr,        pixel write port (drawing side)
//   wr_code
//   rd_en, rd_addr,       pixel read port (scan-out side), 2-cycle latency
//   rd_data, rd_valid
//   clear_req,            full-frame clear request, sweep-in-progress flag,
//   clear_busy,           one-cycle completion pulse
//   clear_done
//   wr_dropped            sticky: some pixel write was discarded
//   pal_we, pal_idx,      palette write port
//   pal_color
//
// Read handshake: there is no back-pressure. Every cycle with rd_en high is a
// read; exactly two clock edges later rd_valid is high for one cycle and
// rd_data holds palette[RAM[rd_addr]] (out-of-range addresses read code 0).
// Outside those cycles rd_valid is low and rd_data must be ignored.
module paint_framebuffer
  import paint_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int CW     = 3,
  localparam int DEPTH = WIDTH * HEIGHT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wren,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_code,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [23:0]   rd_data,
  output logic          rd_valid,
  input  logic          clear_req,
  output logic          clear_busy,
  output logic          clear_done,
  output logic          wr_dropped,
  input  logic          pal_we,
  input  logic [CW-1:0] pal_idx,
  input  logic [23:0]   pal_color
);

  // One extra bit so addresses at or above DEPTH compare correctly even
  // when DEPTH is a power of two.
  localparam logic [AW:0]   DEPTH_X = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [CW-1:0] mem [DEPTH];

  clr_state_t    state;
  logic [AW-1:0] cnt;
  logic          clear_pend;   // clear_req seen in DONE, started from IDLE

  logic          wr_in_range;
  logic          rd_in_range;
  logic          wr_drop;
  logic          sweep_start;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [CW-1:0] ram_code;

  logic [CW-1:0] code_s1;
  logic          valid_s1;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_X;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_X;
  assign wr_drop     = wren && ((state == CLEAR) || !wr_in_range);
  assign sweep_start = (state == IDLE) && (clear_req || clear_pend);

  // The clear engine owns the RAM write port for the whole sweep.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = wr_addr;
    ram_code = wr_code;
    if (state == CLEAR) begin
      ram_we   = 1'b1;
      ram_addr = cnt;
      ram_code = '0;
    end else if (wren && wr_in_range) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_code;
  end

  // Clear engine. Reset enters CLEAR directly so the unreset RAM is wiped
  // after power-up. clear_req during CLEAR is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLEAR;
      cnt        <= '0;
      clear_busy <= 1'b1;
      clear_done <= 1'b0;
      clear_pend <= 1'b0;
      wr_dropped <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req || clear_pend) begin
            state      <= CLEAR;
            cnt        <= '0;
            clear_busy <= 1'b1;
            clear_pend <= 1'b0;
          end
        end
        CLEAR: begin
          if (cnt == LAST) begin
            state      <= DONE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          clear_pend <= clear_req;
        end
        default: begin
          state      <= IDLE;
          clear_busy <= 1'b0;
        end
      endcase

      // A drop in the same cycle a sweep starts still gets reported.
      if (wr_drop) wr_dropped <= 1'b1;
      else if (sweep_start) wr_dropped <= 1'b0;
    end
  end

  // Read stage 1: fetch the code. Non-blocking RAM write gives
  // read-before-write on same-address collisions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_s1  <= '0;
      valid_s1 <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      code_s1  <= rd_in_range ? mem[rd_addr] : '0;
      valid_s1 <= rd_en;
      rd_valid <= valid_s1;
    end
  end

  // Read stage 2: palette lookup.
  paint_palette #(
    .CW (CW)
  ) u_palette (
    .clk     (clk),
    .reset   (reset),
    .we      (pal_we),
    .idx     (pal_idx),
    .color   (pal_color),
    .code    (code_s1),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_paint_framebuffer.sv
// tb_paint_framebuffer: directed tests for paint_framebuffer.
// Instance a: 8x5 (DEPTH=40, AW=6, CW=3) so DEPTH and DEPTH+1 are addressable.
// Instance b: 8x4 (DEPTH=32, AW=5, CW=4) for the mid-sweep reset and the
// 16-entry palette.
module tb_paint_framebuffer;

  localparam int AW_A = 6;
  localparam int CW_A = 3;
  localparam int AW_B = 5;
  localparam int CW_B = 4;

  logic clk;

  // instance a
  logic            reset_a, wren_a, rd_en_a, clear_req_a, pal_we_a;
  logic [AW_A-1:0] wr_addr_a, rd_addr_a;
  logic [CW_A-1:0] wr_code_a, pal_idx_a;
  logic [23:0]     pal_color_a, rd_data_a;
  logic            rd_valid_a, clear_busy_a, clear_done_a, wr_dropped_a;

  // instance b
  logic            reset_b, wren_b, rd_en_b, clear_req_b, pal_we_b;
  logic [AW_B-1:0] wr_addr_b, rd_addr_b;
  logic [CW_B-1:0] wr_code_b, pal_idx_b;
  logic [23:0]     pal_color_b, rd_data_b;
  logic            rd_valid_b, clear_busy_b, clear_done_b, wr_dropped_b;

  int errors = 0;
  int checks = 0;

  paint_framebuffer #(.WIDTH(8), .HEIGHT(5), .CW(CW_A)) dut_a (
    .clk (clk), .reset (reset_a),
    .wren (wren_a), .wr_addr (wr_addr_a), .wr_code (wr_code_a),
    .rd_en (rd_en_a), .rd_addr (rd_addr_a),
    .rd_data (rd_data_a), .rd_valid (rd_valid_a),
    .clear_req (clear_req_a), .clear_busy (clear_busy_a),
    .clear_done (clear_done_a), .wr_dropped (wr_dropped_a),
    .pal_we (pal_we_a), .pal_idx (pal_idx_a), .pal_color (pal_color_a)
  );

  paint_framebuffer #(.WIDTH(8), .HEIGHT(4), .CW(CW_B)) dut_b (
    .clk (clk), .reset (reset_b),
    .wren (wren_b), .wr_addr (wr_addr_b), .wr_code (wr_code_b),
    .rd_en (rd_en_b), .rd_addr (rd_addr_b),
    .rd_data (rd_data_b), .rd_valid (rd_valid_b),
    .clear_req (clear_req_b), .clear_busy (clear_busy_b),
    .clear_done (clear_done_b), .wr_dropped (wr_dropped_b),
    .pal_we (pal_we_b), .pal_idx (pal_idx_b), .pal_color (pal_color_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [AW_A-1:0] addr, input logic [CW_A-1:0] code);
    wren_a = 1'b1; wr_addr_a = addr; wr_code_a = code;
    tick();
    wren_a = 1'b0;
  endtask

  task automatic read_a(input logic [AW_A-1:0] addr, output logic [23:0] data,
                        output logic valid);
    rd_en_a = 1'b1; rd_addr_a = addr;
    tick();
    rd_en_a = 1'b0;
    tick();
    data = rd_data_a; valid = rd_valid_a;
  endtask

  task automatic write_b(input logic [AW_B-1:0] addr, input logic [CW_B-1:0] code);
    wren_b = 1'b1; wr_addr_b = addr; wr_code_b = code;
    tick();
    wren_b = 1'b0;
  endtask

  task automatic read_b(input logic [AW_B-1:0] addr, output logic [23:0] data,
                        output logic valid);
    rd_en_b = 1'b1; rd_addr_b = addr;
    tick();
    rd_en_b = 1'b0;
    tick();
    data = rd_data_b; valid = rd_valid_b;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    logic [23:0] d;
    logic v;
    reset_a = 1'b1;
    tick();
    tick();
    checks++; if (rd_data_a !== 24'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 000000", rd_data_a); end
    checks++; if (rd_valid_a !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid_a); end
    checks++; if (clear_busy_a !== 1'b1) begin errors++; $display("FAIL reset_clear_busy: got %b expected 1", clear_busy_a); end
    checks++; if (clear_done_a !== 1'b0) begin errors++; $display("FAIL reset_clear_done: got %b expected 0", clear_done_a); end
    checks++; if (wr_dropped_a !== 1'b0) begin errors++; $display("FAIL reset_wr_dropped: got %b expected 0", wr_dropped_a); end
    reset_a = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!clear_busy_a) break;
      tick();
      n++;
    end
    checks++; if (n !== 40) begin errors++; $display("FAIL boot_sweep_len: got %0d expected 40", n); end
    checks++; if (clear_done_a !== 1'b1) begin errors++; $display("FAIL boot_done_pulse: got %b expected 1", clear_done_a); end
    tick();
    checks++; if (clear_done_a !== 1'b0) begin errors++; $display("FAIL boot_done_once: got %b expected 0", clear_done_a); end
    checks++; if (clear_busy_a !== 1'b0) begin errors++; $display("FAIL boot_busy_low: got %b expected 0", clear_busy_a); end
    read_a(6'd0, d, v);
    checks++; if (d !== 24'h0 || v !== 1'b1) begin errors++; $display("FAIL boot_read0: got %h/%b expected 000000/1", d, v); end
    read_a(6'd39, d, v);
    checks++; if (d !== 24'h0 || v !== 1'b1) begin errors++; $display("FAIL boot_read39: got %h/%b expected 000000/1", d, v); end
    checks++; if (rd_valid_a !== 1'b1) begin errors++; $display("FAIL valid_width_pre: got %b expected 1", rd_valid_a); end
    tick();
    checks++; if (rd_valid_a !== 1'b0) begin errors++; $display("FAIL valid_one_cycle: got %b expected 0", rd_valid_a); end
  endtask

  task automatic test_write_read();
    logic [23:0] d;
    logic v;
    write_a(6'd10, 3'd3);
    write_a(6'd39, 3'd6);
    read_a(6'd10, d, v);
    checks++; if (d !== 24'hFF0000 || v !== 1'b1) begin errors++; $display("FAIL read_red: got %h/%b expected ff0000/1", d, v); end
    read_a(6'd11, d, v);
    checks++; if (d !== 24'h000000) begin errors++; $display("FAIL read_neighbor: got %h expected 000000", d); end
    read_a(6'd39, d, v);
    checks++; if (d !== 24'h00FF00) begin errors++; $display("FAIL read_last_addr: got %h expected 00ff00", d); end
  endtask

  task automatic test_palette();
    logic [23:0] d;
    logic v;
    // lookup of entry 3 happens on the same edge as its palette write
    rd_en_a = 1'b1; rd_addr_a = 6'd10;
    tick();
    rd_en_a = 1'b0;
    pal_we_a = 1'b1; pal_idx_a = 3'd3; pal_color_a = 24'h123456;
    tick();
    pal_we_a = 1'b0;
    checks++; if (rd_data_a !== 24'hFF0000 || rd_valid_a !== 1'b1) begin errors++; $display("FAIL pal_collision_old: got %h/%b expected ff0000/1", rd_data_a, rd_valid_a); end
    read_a(6'd10, d, v);
    checks++; if (d !== 24'h123456) begin errors++; $display("FAIL pal_new_color: got %h expected 123456", d); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] d;
    logic v;
    rd_en_a = 1'b1; rd_addr_a = 6'd10;
    tick();
    rd_addr_a = 6'd11;
    tick();
    checks++; if (rd_data_a !== 24'h123456 || rd_valid_a !== 1'b1) begin errors++; $display("FAIL b2b_0: got %h/%b expected 123456/1", rd_data_a, rd_valid_a); end
    rd_addr_a = 6'd39;
    tick();
    checks++; if (rd_data_a !== 24'h000000 || rd_valid_a !== 1'b1) begin errors++; $display("FAIL b2b_1: got %h/%b expected 000000/1", rd_data_a, rd_valid_a); end
    rd_en_a = 1'b0;
    tick();
    checks++; if (rd_data_a !== 24'h00FF00 || rd_valid_a !== 1'b1) begin errors++; $display("FAIL b2b_2: got %h/%b expected 00ff00/1", rd_data_a, rd_valid_a); end
    tick();
    checks++; if (rd_valid_a !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", rd_valid_a); end
    // same-address read and write in one cycle
    wren_a = 1'b1; wr_addr_a = 6'd11; wr_code_a = 3'd5;
    rd_en_a = 1'b1; rd_addr_a = 6'd11;
    tick();
    wren_a = 1'b0; rd_en_a = 1'b0;
    tick();
    checks++; if (rd_data_a !== 24'h000000) begin errors++; $display("FAIL rbw_old: got %h expected 000000", rd_data_a); end
    read_a(6'd11, d, v);
    checks++; if (d !== 24'hFFFF00) begin errors++; $display("FAIL rbw_new: got %h expected ffff00", d); end
  endtask

  task automatic test_out_of_range();
    logic [23:0] d;
    logic v;
    checks++; if (wr_dropped_a !== 1'b0) begin errors++; $display("FAIL oor_pre_dropped: got %b expected 0", wr_dropped_a); end
    write_a(6'd40, 3'd1);
    checks++; if (wr_dropped_a !== 1'b1) begin errors++; $display("FAIL oor_dropped: got %b expected 1", wr_dropped_a); end
    read_a(6'd8, d, v);
    checks++; if (d !== 24'h000000) begin errors++; $display("FAIL oor_no_alias: got %h expected 000000", d); end
    read_a(6'd0, d, v);
    checks++; if (d !== 24'h000000) begin errors++; $display("FAIL oor_addr0: got %h expected 000000", d); end
    read_a(6'd41, d, v);
    checks++; if (d !== 24'h000000 || v !== 1'b1) begin errors++; $display("FAIL oor_read: got %h/%b expected 000000/1", d, v); end
  endtask

  task automatic test_clear_drop();
    int n;
    logic [23:0] d;
    logic v;
    clear_req_a = 1'b1;
    tick();
    clear_req_a = 1'b0;
    n = 1;
    checks++; if (clear_busy_a !== 1'b1) begin errors++; $display("FAIL clr_busy: got %b expected 1", clear_busy_a); end
    checks++; if (wr_dropped_a !== 1'b0) begin errors++; $display("FAIL clr_drop_cleared: got %b expected 0", wr_dropped_a); end
    write_a(6'd5, 3'd7);
    n++;
    checks++; if (wr_dropped_a !== 1'b1) begin errors++; $display("FAIL clr_drop_set: got %b expected 1", wr_dropped_a); end
    clear_req_a = 1'b1;   // ignored while sweeping
    tick();
    clear_req_a = 1'b0;
    n++;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!clear_busy_a) break;
      n++;
    end
    checks++; if (n !== 40) begin errors++; $display("FAIL clr_sweep_len: got %0d expected 40", n); end
    checks++; if (clear_done_a !== 1'b1) begin errors++; $display("FAIL clr_done: got %b expected 1", clear_done_a); end
    // a clear_req seen in DONE restarts via IDLE
    clear_req_a = 1'b1;
    tick();
    clear_req_a = 1'b0;
    checks++; if (clear_busy_a !== 1'b0 || wr_dropped_a !== 1'b1) begin errors++; $display("FAIL clr_idle_gap: got busy=%b dropped=%b expected 0/1", clear_busy_a, wr_dropped_a); end
    tick();
    checks++; if (clear_busy_a !== 1'b1 || wr_dropped_a !== 1'b0) begin errors++; $display("FAIL clr_restart: got busy=%b dropped=%b expected 1/0", clear_busy_a, wr_dropped_a); end
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!clear_busy_a) break;
      tick();
      n++;
    end
    checks++; if (n !== 40) begin errors++; $display("FAIL clr_second_len: got %0d expected 40", n); end
    read_a(6'd5, d, v);
    checks++; if (d !== 24'h000000) begin errors++; $display("FAIL clr_addr5: got %h expected 000000", d); end
    read_a(6'd10, d, v);
    checks++; if (d !== 24'h000000) begin errors++; $display("FAIL clr_addr10: got %h expected 000000", d); end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    logic [23:0] d;
    logic v;
    reset_b = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rd_en_b = 1'b1; rd_addr_b = 5'd0;
    wren_b = 1'b1; wr_addr_b = 5'd2; wr_code_b = 4'd1;
    tick();
    rd_en_b = 1'b0; wren_b = 1'b0;
    tick();
    // sweep counter is now 10
    checks++; if (rd_valid_b !== 1'b1 || wr_dropped_b !== 1'b1 || clear_busy_b !== 1'b1) begin errors++; $display("FAIL mid_pre: got valid=%b dropped=%b busy=%b expected 1/1/1", rd_valid_b, wr_dropped_b, clear_busy_b); end
    reset_b = 1'b1;
    #1;
    checks++; if (rd_valid_b !== 1'b0 || rd_data_b !== 24'h0) begin errors++; $display("FAIL mid_reset_rd: got %h/%b expected 000000/0", rd_data_b, rd_valid_b); end
    checks++; if (wr_dropped_b !== 1'b0 || clear_done_b !== 1'b0 || clear_busy_b !== 1'b1) begin errors++; $display("FAIL mid_reset_flags: got dropped=%b done=%b busy=%b expected 0/0/1", wr_dropped_b, clear_done_b, clear_busy_b); end
    tick();
    reset_b = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!clear_busy_b) break;
      tick();
      n++;
    end
    checks++; if (n !== 32) begin errors++; $display("FAIL mid_rerun_len: got %0d expected 32", n); end
    checks++; if (clear_done_b !== 1'b1) begin errors++; $display("FAIL mid_rerun_done: got %b expected 1", clear_done_b); end
    write_b(5'd3, 4'd12);
    write_b(5'd4, 4'd4);
    read_b(5'd3, d, v);
    checks++; if (d !== 24'h000000 || v !== 1'b1) begin errors++; $display("FAIL pal12_default: got %h/%b expected 000000/1", d, v); end
    read_b(5'd4, d, v);
    checks++; if (d !== 24'h0000FF) begin errors++; $display("FAIL pal4_default_b: got %h expected 0000ff", d); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_a = 1'b1; wren_a = 1'b0; rd_en_a = 1'b0; clear_req_a = 1'b0; pal_we_a = 1'b0;
    wr_addr_a = '0; rd_addr_a = '0; wr_code_a = '0; pal_idx_a = '0; pal_color_a = '0;
    reset_b = 1'b1; wren_b = 1'b0; rd_en_b = 1'b0; clear_req_b = 1'b0; pal_we_b = 1'b0;
    wr_addr_b = '0; rd_addr_b = '0; wr_code_b = '0; pal_idx_b = '0; pal_color_b = '0;

    test_reset();
    test_write_read();
    test_palette();
    test_back_to_back();
    test_out_of_range();
    test_clear_drop();
    test_reset_mid_sweep();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/paint_framebuffer.md
Name: paint_framebuffer

Overview:
- Parametrised paint framebuffer: one color code per pixel in a WIDTH x HEIGHT on-chip RAM, translated to 24-bit RGB through a programmable palette.
- Sits between the drawing/input logic (write side) and the VGA scan-out (read side).
- Adds a hardware clear engine with busy/done handshake, a registered 2-stage read pipeline, range checking and dropped-write reporting.

Parameters:
- WIDTH, 640, pixels per line.
- HEIGHT, 480, lines per frame.
- CW, 3, color-code width in bits; must be >= 3 (palette depth 2**CW).
- DEPTH (localparam), WIDTH*HEIGHT, pixel count.
- AW (localparam), $clog2(DEPTH), address width.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- wren  in  1  pixel write strobe.
- wr_addr  in  AW  pixel write address.
- wr_code  in  CW  color code to write.
- rd_en  in  1  read request.
- rd_addr  in  AW  pixel read address.
- rd_data  out  24  RGB result.
- rd_valid  out  1  rd_data qualifies the rd_en issued 2 cycles earlier.
- clear_req  in  1  start a full-frame clear (level or pulse).
- clear_busy  out  1  clear sweep in progress.
- clear_done  out  1  one-cycle pulse when a sweep completes.
- wr_dropped  out  1  sticky flag: a pixel write was discarded.
- pal_we  in  1  palette write strobe.
- pal_idx  in  CW  palette entry to write.
- pal_color  in  24  RGB value for pal_idx.

Behaviour:
Reset values:
- rd_data=0, rd_valid=0, clear_done=0, wr_dropped=0, clear_busy=1, FSM=CLEAR, sweep counter=0.
- Palette loads defaults: 0:000000, 1:FFFFFF, 2:000001, 3:FF0000, 4:0000FF, 5:FFFF00, 6:00FF00, 7:FF00FF, idx>=8:000000.
- Pixel RAM has no reset port; power-up contents are cleared by the automatic sweep after reset.

FSM states:
- IDLE: on clear_req -> CLEAR with counter=0.
- CLEAR: write code 0 to RAM[counter], counter+1 each cycle. At counter==DEPTH-1 write, then -> DONE. A sweep takes exactly DEPTH cycles.
- DONE: clear_done=1 for this cycle, clear_busy=0, -> IDLE. A clear_req seen in DONE is honoured next cycle, IDLE -> CLEAR.

clear_busy and clear_req rules:
- clear_busy=1 exactly while in CLEAR.
- clear_req while in CLEAR is ignored; it does not restart or extend the sweep.

Write side:
- In IDLE/DONE, wren with wr_addr<DEPTH writes wr_code at the clock edge.
- wren with wr_addr>=DEPTH is discarded and sets wr_dropped.
- wren while in CLEAR is discarded and sets wr_dropped; the clear engine owns the write port.
- wr_dropped stays set until the cycle a new sweep starts (IDLE -> CLEAR), or reset.

Read pipeline (latency 2, one read per cycle, fully pipelined, no stalls):
- Stage 1 registers the code from RAM[rd_addr]; rd_addr>=DEPTH yields code 0.
- Stage 2 registers palette[code] into rd_data; rd_valid is rd_en delayed 2 cycles.
- Reads are allowed during CLEAR and return current RAM contents.
- Same-address read and write in one cycle: read returns old data (read-before-write).
- Palette write in the same cycle as a stage-2 lookup of that index: lookup returns the old color.

Reset asserted mid-sweep or mid-read:
- Pipeline is flushed; rd_valid=0 immediately (asynchronous).
- Sweep restarts from 0 after release.

Decomposition:
- Package paint_pkg holds:
  - rgb_t, a 24-bit typedef.
  - Default palette constant array, indexed by code.
  - Named code constants: ERASE=0, WHITE=1, BLACK=2, RED=3, BLUE=4, YELLOW=5, GREEN=6, PURPLE=7.
  - clr_state_t enum {IDLE, CLEAR, DONE}.
- Sub-module paint_palette: 2**CW x 24 register file, asynchronously reset to the paint_pkg defaults, one write port, one registered read port. It forms stage 2 of the pipeline.

Test Plan:
- Reset release -> clear_busy=1 for exactly DEPTH cycles, then clear_done pulses once; afterwards a read of any address returns 000000 with rd_valid 2 cycles after rd_en.
- After the sweep, write code 3 at address 100, read address 100 -> rd_data=FF0000 two cycles later. Read address 101 -> 000000.
- pal_we with idx 3 and color 123456, then read address 100 -> 123456. In a same-cycle palette-write/lookup collision, the first read shows FF0000 and the next shows 123456.
- clear_req, then wren to address 5 during the sweep -> write discarded, wr_dropped=1. After clear_done, address 5 reads 000000; wr_dropped stays 1 until the next clear_req starts a sweep.
- wren with wr_addr=DEPTH -> wr_dropped=1 and no RAM change. Read of rd_addr=DEPTH+1 -> 000000.
- Use a small config (WIDTH=8, HEIGHT=4, CW=4) and assert reset at sweep counter 10 -> all outputs at reset values at once; the sweep reruns a full 32 cycles after release. Palette entry 12 reads 000000 by default.
